// File: rtl/counter_digit_pkg.sv
// Shared constants and types for the 4-digit BCD scan counter.
// Digit index encoding, BCD limits and active-low anode patterns.
package counter_digit_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  localparam logic [NUM_DIGITS-1:0] AN_D0  = 4'b1110;
  localparam logic [NUM_DIGITS-1:0] AN_D1  = 4'b1101;
  localparam logic [NUM_DIGITS-1:0] AN_D2  = 4'b1011;
  localparam logic [NUM_DIGITS-1:0] AN_D3  = 4'b0111;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  typedef enum logic [1:0] {
    DIG_ONES      = 2'd0,
    DIG_TENS      = 2'd1,
    DIG_HUNDREDS  = 2'd2,
    DIG_THOUSANDS = 2'd3
  } digit_idx_e;

  // One-cold anode pattern for a scan position.
  function automatic logic [NUM_DIGITS-1:0] anode_for(input digit_idx_e idx);
    case (idx)
      DIG_ONES:      return AN_D0;
      DIG_TENS:      return AN_D1;
      DIG_HUNDREDS:  return AN_D2;
      DIG_THOUSANDS: return AN_D3;
      default:       return AN_OFF;
    endcase
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade (0..9) with up/down enables and ripple carry/borrow
// outputs that fire combinationally on the step that rolls the decade over.
module bcd_decade
  import counter_digit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_up,
  input  logic               en_dn,
  input  logic               clr,
  output logic [DIGIT_W-1:0] value,
  output logic               carry_out,
  output logic               borrow_out
);

  logic [DIGIT_W-1:0] r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (clr) begin
      r_value <= '0;
    end else if (en_up) begin
      r_value <= (r_value == BCD_MAX) ? '0 : r_value + DIGIT_W'(1);
    end else if (en_dn) begin
      r_value <= (r_value == '0) ? BCD_MAX : r_value - DIGIT_W'(1);
    end
  end

  assign value      = r_value;
  // Up takes precedence so the two ripple outputs are never both active.
  assign carry_out  = en_up & ~clr & (r_value == BCD_MAX);
  assign borrow_out = en_dn & ~en_up & ~clr & (r_value == '0);

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-decade BCD up/down counter with a multiplexed 7-segment scan:
// prescaled digit index, registered number/anode, optional leading-zero blanking.
module bcd_scan_counter
  import counter_digit_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  clr,
  output logic [DIGIT_W-1:0]    number,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  wrap
);

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0]      r_pre;
  digit_idx_e            r_idx;
  logic [DIGIT_W-1:0]    r_number;
  logic [NUM_DIGITS-1:0] r_anode;
  logic                  r_wrap;

  logic                  w_up0;
  logic                  w_dn0;
  logic                  w_c0, w_c1, w_c2, w_c3;
  logic                  w_b0, w_b1, w_b2, w_b3;
  logic [DIGIT_W-1:0]    w_d0, w_d1, w_d2, w_d3;
  logic [DIGIT_W-1:0]    w_sel_digit;
  logic [NUM_DIGITS-1:0] w_blank;

  // inc and dec together cancel; clr overrides both inside each decade.
  assign w_up0 = inc & ~dec & ~clr;
  assign w_dn0 = dec & ~inc & ~clr;

  bcd_decade u_dec0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_up      (w_up0),
    .en_dn      (w_dn0),
    .clr        (clr),
    .value      (w_d0),
    .carry_out  (w_c0),
    .borrow_out (w_b0)
  );

  bcd_decade u_dec1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_up      (w_c0),
    .en_dn      (w_b0),
    .clr        (clr),
    .value      (w_d1),
    .carry_out  (w_c1),
    .borrow_out (w_b1)
  );

  bcd_decade u_dec2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_up      (w_c1),
    .en_dn      (w_b1),
    .clr        (clr),
    .value      (w_d2),
    .carry_out  (w_c2),
    .borrow_out (w_b2)
  );

  bcd_decade u_dec3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_up      (w_c2),
    .en_dn      (w_b2),
    .clr        (clr),
    .value      (w_d3),
    .carry_out  (w_c3),
    .borrow_out (w_b3)
  );

  // A digit is blanked when it and every higher digit are zero; ones never blank.
  assign w_blank[0] = 1'b0;
  assign w_blank[1] = BLANK_LZ & (w_d1 == '0) & (w_d2 == '0) & (w_d3 == '0);
  assign w_blank[2] = BLANK_LZ & (w_d2 == '0) & (w_d3 == '0);
  assign w_blank[3] = BLANK_LZ & (w_d3 == '0);

  always_comb begin
    w_sel_digit = '0;
    case (r_idx)
      DIG_ONES:      w_sel_digit = w_d0;
      DIG_TENS:      w_sel_digit = w_d1;
      DIG_HUNDREDS:  w_sel_digit = w_d2;
      DIG_THOUSANDS: w_sel_digit = w_d3;
      default:       w_sel_digit = '0;
    endcase
  end

  // Scan runs free of the count; outputs reflect the pre-edge count and index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre    <= '0;
      r_idx    <= DIG_ONES;
      r_number <= '0;
      r_anode  <= AN_D0;
      r_wrap   <= 1'b0;
    end else begin
      if (r_pre == PRE_LAST) begin
        r_pre <= '0;
        r_idx <= digit_idx_e'(r_idx + 2'd1);
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
      r_number <= w_sel_digit;
      r_anode  <= w_blank[r_idx] ? AN_OFF : anode_for(r_idx);
      r_wrap   <= w_c3 | w_b3;
    end
  end

  assign number = r_number;
  assign anode  = r_anode;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter (SCAN_DIV=4) with one blanking and one
// non-blanking instance, checked every cycle against an arithmetic model.
module tb_bcd_scan_counter;

  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic inc, dec, clr;
  logic [3:0] num_n, an_n, num_b, an_b;
  logic wrap_n, wrap_b;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: integer count 0..9999, prescaler, scan index.
  int m_cnt, m_pre, m_idx, m_sel;
  logic [3:0] e_num, e_an_n, e_an_b;
  logic e_wrap;

  always #5 clk = ~clk;

  bcd_scan_counter #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .clr(clr),
    .number(num_n), .anode(an_n), .wrap(wrap_n)
  );

  bcd_scan_counter #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .clr(clr),
    .number(num_b), .anode(an_b), .wrap(wrap_b)
  );

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_pre = 0; m_idx = 0; m_sel = 0;
      e_num = 4'd0; e_an_n = 4'b1110; e_an_b = 4'b1110; e_wrap = 1'b0;
    end else begin
      m_sel  = m_idx;
      e_num  = 4'((m_cnt / pow10(m_idx)) % 10);
      e_an_n = 4'hF ^ 4'(1 << m_idx);
      e_an_b = (m_idx != 0 && m_cnt < pow10(m_idx)) ? 4'hF : e_an_n;
      e_wrap = 1'b0;
      if (clr) m_cnt = 0;
      else if (inc && dec) m_cnt = m_cnt;
      else if (inc) begin
        if (m_cnt == 9999) begin m_cnt = 0; e_wrap = 1'b1; end
        else m_cnt = m_cnt + 1;
      end else if (dec) begin
        if (m_cnt == 0) begin m_cnt = 9999; e_wrap = 1'b1; end
        else m_cnt = m_cnt - 1;
      end
      if (m_pre == SCAN_DIV - 1) begin m_pre = 0; m_idx = (m_idx + 1) % 4; end
      else m_pre = m_pre + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_cmp++;
      if (num_n !== e_num || num_b !== e_num || an_n !== e_an_n ||
          an_b !== e_an_b || wrap_n !== e_wrap || wrap_b !== e_wrap) begin
        n_err++;
        $display("FAIL model t=%0t: number %0d/%0d anode %b/%b wrap %b/%b, required number %0d anode %b/%b wrap %b",
                 $time, num_n, num_b, an_n, an_b, wrap_n, wrap_b, e_num, e_an_n, e_an_b, e_wrap);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic hold(input int n, input logic i, input logic d, input logic c);
    inc = i; dec = d; clr = c;
    repeat (n) @(negedge clk);
    inc = 1'b0; dec = 1'b0; clr = 1'b0;
  endtask

  // One full scan: nums/anb packed per index, index k in bits [4k+3:4k].
  task automatic scan_expect(input string name, input logic [15:0] nums, input logic [15:0] anb);
    logic [15:0] onecold;
    onecold = 16'h7BDE;
    for (int c = 0; c < 4 * SCAN_DIV; c++) begin
      @(negedge clk);
      chk({name, " number_n"}, 16'(num_n), 16'(nums[4*m_sel +: 4]));
      chk({name, " number_b"}, 16'(num_b), 16'(nums[4*m_sel +: 4]));
      chk({name, " anode_n"},  16'(an_n),  16'(onecold[4*m_sel +: 4]));
      chk({name, " anode_b"},  16'(an_b),  16'(anb[4*m_sel +: 4]));
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, " number_n"}, 16'(num_n), 16'h0);
    chk({name, " number_b"}, 16'(num_b), 16'h0);
    chk({name, " anode_n"},  16'(an_n),  16'hE);
    chk({name, " anode_b"},  16'(an_b),  16'hE);
    chk({name, " wrap"},     16'({wrap_n, wrap_b}), 16'h0);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; inc = 1'b1; dec = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("in_reset");
    inc = 1'b0;
    rst_n = 1'b1;
    // Index advances on the 4th edge; anodes follow one edge later.
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      chk($sformatf("post_rst e%0d anode_n", e), 16'(an_n), (e < 5) ? 16'hE : 16'hD);
      chk($sformatf("post_rst e%0d anode_b", e), 16'(an_b), (e < 5) ? 16'hE : 16'hF);
      chk($sformatf("post_rst e%0d number", e), 16'(num_n), 16'h0);
    end

    hold(1234, 1'b1, 1'b0, 1'b0);
    scan_expect("c1234", 16'h1234, 16'h7BDE);

    hold(1, 1'b0, 1'b0, 1'b1);
    hold(9999, 1'b1, 1'b0, 1'b0);
    scan_expect("c9999", 16'h9999, 16'h7BDE);
    hold(1, 1'b1, 1'b0, 1'b0);
    chk("wrap_up pulse", 16'({wrap_n, wrap_b}), 16'h3);
    @(negedge clk);
    chk("wrap_up drop", 16'({wrap_n, wrap_b}), 16'h0);
    scan_expect("c0000", 16'h0000, 16'hFFFE);
    hold(1, 1'b0, 1'b1, 1'b0);
    chk("wrap_dn pulse", 16'({wrap_n, wrap_b}), 16'h3);
    @(negedge clk);
    chk("wrap_dn drop", 16'({wrap_n, wrap_b}), 16'h0);
    scan_expect("c9999b", 16'h9999, 16'h7BDE);

    hold(1, 1'b0, 1'b0, 1'b1);
    hold(50, 1'b1, 1'b0, 1'b0);
    scan_expect("c0050", 16'h0050, 16'hFFDE);
    hold(1, 1'b1, 1'b1, 1'b0);
    chk("incdec wrap", 16'({wrap_n, wrap_b}), 16'h0);
    scan_expect("c0050b", 16'h0050, 16'hFFDE);
    hold(1, 1'b1, 1'b0, 1'b1);
    chk("clrinc wrap", 16'({wrap_n, wrap_b}), 16'h0);
    scan_expect("clrinc", 16'h0000, 16'hFFFE);

    hold(7, 1'b1, 1'b0, 1'b0);
    scan_expect("c0007", 16'h0007, 16'hFFFE);
    hold(1, 1'b0, 1'b0, 1'b1);
    hold(100, 1'b1, 1'b0, 1'b0);
    scan_expect("c0100", 16'h0100, 16'hFBDE);

    hold(1, 1'b0, 1'b0, 1'b1);
    hold(42, 1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      if (m_idx == 2) found = 1'b1;
    end
    chk("wait idx2", 16'(found), 16'h1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid_reset");
    repeat (3) @(negedge clk);
    chk_reset_vals("mid_reset held");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post mid_reset wrap", 16'({wrap_n, wrap_b}), 16'h0);
    scan_expect("restart", 16'h0000, 16'hFFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
